reg_file_mp: RTL and testbench
==============================

# reg_file_mp

Parametrised multi-read-port register file with an integrated pending-write scoreboard and a post-reset clear sequencer. It replaces the fixed 32×32, 2-read-port register file in the pipeline's decode stage. It lets wider or deeper configurations and extra read ports, for example for a dual-issue front end, share one storage block. The scoreboard marks registers awaiting writeback so hazard logic can stall without tracking destinations itself.

## Interface
- WIDTH, 32, data width in bits
- DEPTH, 32, number of registers; must be a power of two and at least 2; AW = $clog2(DEPTH)
- NRD, 2, number of read ports, 1..4

- clk  in  1  clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- rdy  out  1  high once the clear sequence is complete; reset value 0
- ra  in  NRD*AW  read addresses; port i uses bits [i*AW +: AW]
- rd  out  NRD*WIDTH  read data; port i uses bits [i*WIDTH +: WIDTH]
- rpend  out  NRD  port i reads a register with a write outstanding
- we  in  1  write enable, active high
- wa  in  AW  write address
- wd  in  WIDTH  write data
- alloc  in  1  mark register alloc_a as pending
- alloc_a  in  AW  destination register being allocated

## Operation
- Register 0 is hardwired to zero:
  - Writes to address 0 are discarded.
  - Allocations of address 0 are discarded.
  - Reads of address 0 return 0 with rpend=0.
- Storage is not reset. A two-state FSM (INIT, RUN) zeroes the storage instead.
- INIT state:
  - Entered asynchronously whenever rst_n=0. The clear pointer is set to 1, pend[] is set to all 0, and rdy=0.
  - After rst_n rises, each clock writes 0 to rf[ptr] and increments ptr.
  - On the cycle ptr==DEPTH-1 is written, the FSM moves to RUN and rdy goes high.
  - we and alloc are ignored throughout INIT.
  - While rdy=0, every read port returns rd=0 and rpend=0.
- RUN state:
  - If we=1 and wa≠0, rf[wa] ← wd and pend[wa] ← 0.
  - If alloc=1 and alloc_a≠0, pend[alloc_a] ← 1.
  - Simultaneous write and alloc to the same address: the data is written and pend ends at 1, because the new producer wins.
  - Read ports are combinational and independent; any number of ports may read the same address.
  - Without bypass, a read returns the stored rf[ra] and rpend = pend[ra] as registered.
- The FSM leaves RUN only through reset. A reset asserted mid-operation immediately drops rdy, clears pend, and restarts the full clear sequence.

## Timing
- Clear latency: rdy rises on the DEPTH-1th rising edge after rst_n deasserts. With DEPTH=32, that is 31 cycles.
- Write to read latency: without bypass, data written at edge N is visible on rd combinationally after edge N. With bypass, it is visible in the same cycle as the write.
- alloc at edge N makes rpend=1 visible after edge N. It is never visible in the same cycle.
- Reset values: rdy=0, rd=0, rpend=0; internal ptr=1, state=INIT.

## Configuration
- REGFILE_BYPASS_EN controls write-through forwarding.
- Defined: in RUN, when we=1, wa≠0 and ra_i==wa, port i returns rd_i=wd. rpend_i is pend[ra_i] with the clear from that write already applied, i.e. 0.
- Not defined: reads always return the stored value and registered pend; no forwarding path exists.

## Test plan
- Clear sequence, DEPTH=32:
  - Hold rst_n low for 3 cycles, then release.
  - rdy must be 0 for 30 edges and rise after edge 31.
  - All 32 addresses then read 0 with rpend=0.
- Write/read across ports:
  - Write 0xDEADBEEF to r5.
  - The next cycle, with NRD=4 all reading r5, every port shows 0xDEADBEEF.
  - A write of 0x1234 to r0 leaves reads of r0 at 0.
- Scoreboard:
  - alloc r7, then hold 2 cycles: rpend=1 on any port reading r7.
  - Then write r7 with 0x55: after that edge rpend=0 and rd=0x55.
  - Simultaneous we and alloc on r9: rd=new data, rpend=1.
- Bypass:
  - Write 0xA5A5A5A5 to r3 while port 1 reads r3.
  - With REGFILE_BYPASS_EN, rd1 shows 0xA5A5A5A5 in the same cycle.
  - Without the macro, rd1 shows the old value until the next edge.
- Reset mid-operation:
  - Allocate r4, write r6=0x77, then pulse rst_n low for 1 cycle asynchronously.
  - rdy drops at once and rpend clears.
  - After the re-clear completes, r6 reads 0 and r4 shows rpend=0.
- Writes in INIT:
  - Issue we=1, wa=2, wd=0xFF and alloc r2 while rdy=0.
  - After rdy rises, r2 reads 0 with rpend=0.

Source files
------------

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-read-port register file with pending-write scoreboard and post-reset clear sequencer.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module reg_file_mp #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int NRD = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               rdy,
  input  logic [NRD*AW-1:0]  ra,
  output logic [NRD*WIDTH-1:0] rd,
  output logic [NRD-1:0]     rpend,
  input  logic               we,
  input  logic [AW-1:0]      wa,
  input  logic [WIDTH-1:0]   wd,
  input  logic               alloc,
  input  logic [AW-1:0]      alloc_a
);
  typedef enum logic {INIT, RUN} state_t;
  state_t           r_state;
  logic [AW-1:0]    r_ptr;
  logic             r_rdy;
  logic [DEPTH-1:0] r_pend;
  logic [WIDTH-1:0] r_rf [DEPTH];
  logic             w_wr;
  assign w_wr = r_state == RUN && we && wa != '0;
  assign rdy = r_rdy;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= INIT;
      r_ptr <= AW'(1);
      r_rdy <= 1'b0;
      r_pend <= '0;
    end else if (r_state == INIT) begin
      r_ptr <= r_ptr + AW'(1);
      if (r_ptr == AW'(DEPTH - 1)) begin
        r_state <= RUN;
        r_rdy <= 1'b1;
      end
    end else begin
      if (w_wr) r_pend[wa] <= 1'b0;
      if (alloc && alloc_a != '0) r_pend[alloc_a] <= 1'b1;
    end
  // Storage has no reset; the INIT sweep zeroes it instead.
  always_ff @(posedge clk)
    if (r_state == INIT) r_rf[r_ptr] <= '0;
    else if (w_wr) r_rf[wa] <= wd;
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] w_a;
    logic          w_byp;
    assign w_a = ra[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
    assign w_byp = w_wr && w_a == wa;
`else
    assign w_byp = 1'b0;
`endif
    assign rd[i*WIDTH +: WIDTH] = (!r_rdy || w_a == '0) ? '0 : w_byp ? wd : r_rf[w_a];
    assign rpend[i] = r_rdy && w_a != '0 && !w_byp && r_pend[w_a];
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: randomized and directed checks of reg_file_mp against an array-based model.
module tb_reg_file_mp;
  localparam int W = 32, D = 32, N = 4, AW = 5;
  logic clk = 0, rst_n = 0, rdy, we = 0, alloc = 0;
  logic [N*AW-1:0] ra = '0;
  logic [N*W-1:0] rd;
  logic [N-1:0] rpend;
  logic [AW-1:0] wa = '0, alloc_a = '0;
  logic [W-1:0] wd = '0;
  int checks = 0, errors = 0;
  logic [W-1:0] m_rf [D];
  logic m_pend [D];
  logic m_rdy = 0;
  int m_cnt = 0;
  reg_file_mp #(.WIDTH(W), .DEPTH(D), .NRD(N)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .ra(ra), .rd(rd), .rpend(rpend),
    .we(we), .wa(wa), .wd(wd), .alloc(alloc), .alloc_a(alloc_a)
  );
  always #10 clk = ~clk;
  function automatic logic [W-1:0] exp_rd(int a);
    if (!m_rdy || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we && wa != 0 && a == int'(wa)) return wd;
`endif
    return m_rf[a];
  endfunction
  function automatic logic exp_pend(int a);
    if (!m_rdy || a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (we && wa != 0 && a == int'(wa)) return 1'b0;
`endif
    return m_pend[a];
  endfunction
  task automatic model_reset;
    m_rdy = 0;
    m_cnt = 0;
    foreach (m_pend[i]) m_pend[i] = 0;
  endtask
  task automatic step;
    @(posedge clk);
    if (rst_n) begin
      if (!m_rdy) begin
        m_cnt++;
        if (m_cnt == D - 1) begin
          m_rdy = 1;
          foreach (m_rf[i]) m_rf[i] = '0;
        end
      end else begin
        if (we && wa != 0) begin m_rf[wa] = wd; m_pend[wa] = 0; end
        if (alloc && alloc_a != 0) m_pend[alloc_a] = 1;
      end
    end
    #1;
  endtask
  task automatic set_all(int a);
    for (int p = 0; p < N; p++) ra[p*AW +: AW] = AW'(a);
  endtask
  task automatic test_reset;
    rst_n = 0;
    model_reset();
    set_all(5);
    repeat (3) step();
    checks++;
    if (rdy !== 1'b0 || rd !== '0 || rpend !== '0) begin
      errors++; $display("FAIL reset_state rdy=%b rd=%h rpend=%b want 0", rdy, rd, rpend);
    end
    #4 rst_n = 1;
    for (int e = 1; e <= D - 1; e++) begin
      step();
      checks++;
      if (rdy !== (e == D - 1)) begin
        errors++; $display("FAIL clear_rdy edge %0d rdy=%b want %b", e, rdy, e == D - 1);
      end
    end
    for (int a = 0; a < D; a++) begin
      ra[(a%N)*AW +: AW] = AW'(a);
      #1;
      checks++;
      if (rd[(a%N)*W +: W] !== '0 || rpend[a%N] !== 1'b0) begin
        errors++; $display("FAIL clear_read r%0d rd=%h rpend=%b want 0/0", a, rd[(a%N)*W +: W], rpend[a%N]);
      end
    end
  endtask
  task automatic test_write_read;
    we = 1; wa = 5; wd = 32'hDEADBEEF;
    step();
    we = 0;
    set_all(5);
    #1;
    for (int p = 0; p < N; p++) begin
      checks++;
      if (rd[p*W +: W] !== 32'hDEADBEEF) begin
        errors++; $display("FAIL wr_rd port%0d rd=%h want deadbeef", p, rd[p*W +: W]);
      end
    end
    we = 1; wa = 0; wd = 32'h1234;
    step();
    we = 0;
    set_all(0);
    #1;
    checks++;
    if (rd !== '0 || rpend !== '0) begin
      errors++; $display("FAIL r0_write rd=%h rpend=%b want 0", rd, rpend);
    end
  endtask
  task automatic test_scoreboard;
    alloc = 1; alloc_a = 7;
    step();
    alloc = 0;
    repeat (2) step();
    set_all(7);
    #1;
    checks++;
    if (rpend !== 4'b1111) begin
      errors++; $display("FAIL alloc_pend rpend=%b want 1111", rpend);
    end
    we = 1; wa = 7; wd = 32'h55;
    step();
    we = 0;
    #1;
    checks++;
    if (rpend !== 4'b0000 || rd[W-1:0] !== 32'h55) begin
      errors++; $display("FAIL wb_clear rpend=%b rd0=%h want 0000/55", rpend, rd[W-1:0]);
    end
    we = 1; wa = 9; wd = 32'h99; alloc = 1; alloc_a = 9;
    step();
    we = 0; alloc = 0;
    set_all(9);
    #1;
    checks++;
    if (rpend !== 4'b1111 || rd[W +: W] !== 32'h99) begin
      errors++; $display("FAIL wr_alloc_same rpend=%b rd1=%h want 1111/99", rpend, rd[W +: W]);
    end
  endtask
  task automatic test_bypass;
    logic [W-1:0] want;
    we = 1; wa = 3; wd = 32'h11;
    step();
    set_all(0);
    ra[AW +: AW] = 3;
    wd = 32'hA5A5A5A5;
`ifdef REGFILE_BYPASS_EN
    want = 32'hA5A5A5A5;
`else
    want = 32'h11;
`endif
    #1;
    checks++;
    if (rd[W +: W] !== want || rpend[1] !== 1'b0) begin
      errors++; $display("FAIL bypass_same rd1=%h rpend1=%b want %h/0", rd[W +: W], rpend[1], want);
    end
    step();
    we = 0;
    #1;
    checks++;
    if (rd[W +: W] !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL bypass_next rd1=%h want a5a5a5a5", rd[W +: W]);
    end
  endtask
  task automatic test_reset_mid;
    alloc = 1; alloc_a = 4;
    step();
    alloc = 0; we = 1; wa = 6; wd = 32'h77;
    step();
    we = 0;
    set_all(4);
    #1;
    checks++;
    if (rpend !== 4'b1111) begin
      errors++; $display("FAIL mid_pre rpend=%b want 1111", rpend);
    end
    #4 rst_n = 0;
    model_reset();
    #1;
    checks++;
    if (rdy !== 1'b0 || rpend !== '0) begin
      errors++; $display("FAIL mid_drop rdy=%b rpend=%b want 0/0", rdy, rpend);
    end
    step();
    #4 rst_n = 1;
    for (int i = 0; i < 40 && !rdy; i++) step();
    checks++;
    if (rdy !== 1'b1 || m_rdy !== 1'b1) begin
      errors++; $display("FAIL mid_reclear rdy=%b model=%b want 1", rdy, m_rdy);
    end
    ra[0 +: AW] = 6;
    #1;
    checks++;
    if (rd[W-1:0] !== '0 || rpend[1] !== 1'b0) begin
      errors++; $display("FAIL mid_after r6=%h r4pend=%b want 0/0", rd[W-1:0], rpend[1]);
    end
  endtask
  task automatic test_init_writes;
    #4 rst_n = 0;
    model_reset();
    step();
    #4 rst_n = 1;
    step();
    we = 1; wa = 2; wd = 32'hFF; alloc = 1; alloc_a = 2;
    for (int i = 0; i < 40 && !rdy; i++) step();
    we = 0; alloc = 0;
    checks++;
    if (rdy !== 1'b1) begin
      errors++; $display("FAIL init_rdy rdy=%b want 1", rdy);
    end
    set_all(2);
    #1;
    checks++;
    if (rd !== '0 || rpend !== '0) begin
      errors++; $display("FAIL init_ignore rd=%h rpend=%b want 0", rd, rpend);
    end
  endtask
  task automatic test_random;
    int a;
    for (int c = 0; c < 400; c++) begin
      we = 1'($urandom_range(0, 1));
      wa = AW'($urandom_range(0, D - 1));
      wd = $urandom;
      alloc = 1'($urandom_range(0, 2) == 0);
      alloc_a = $urandom_range(0, 3) == 0 ? wa : AW'($urandom_range(0, D - 1));
      for (int p = 0; p < N; p++)
        ra[p*AW +: AW] = $urandom_range(0, 2) == 0 ? wa : AW'($urandom_range(0, D - 1));
      #1;
      for (int p = 0; p < N; p++) begin
        a = int'(ra[p*AW +: AW]);
        checks++;
        if (rd[p*W +: W] !== exp_rd(a) || rpend[p] !== exp_pend(a)) begin
          errors++;
          $display("FAIL rand c%0d port%0d r%0d rd=%h rpend=%b want %h/%b", c, p, a, rd[p*W +: W], rpend[p], exp_rd(a), exp_pend(a));
        end
      end
      step();
    end
    we = 0; alloc = 0;
  endtask
  initial begin
    test_reset();
    test_write_read();
    test_scoreboard();
    test_bypass();
    test_random();
    test_reset_mid();
    test_init_writes();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
